// File: rtl/mips_pkg.sv
// mips_pkg: shared word width, data-memory FSM state type and index-width helper.
//   WORD_W        data word width in bits
//   dmem_state_t  data-memory controller states
//   idx_w()       word-index width for a RAM of the given depth
package mips_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } dmem_state_t;

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous RAM with write enable and registered read port.
//   clock, reset  clock and synchronous active-high reset (clears only the read register)
//   we, re        write enable, read enable (read register updates only when re)
//   addr          word index
//   wdata, rdata  write data, registered read data
module dmem_ram
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          we,
    input  logic                          re,
    input  logic [idx_w(DEPTH_WORDS)-1:0] addr,
    input  logic [WORD_W-1:0]             wdata,
    output logic [WORD_W-1:0]             rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_d, rdata_q;

    // Read register holds its value between reads so it can serve as the load-result latch
    always_comb rdata_d = re ? mem[addr] : rdata_q;

    always_ff @(posedge clock) begin
        if (we) mem[addr] <= wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_controller.sv
// dmem_controller: word load/store stage with configurable wait states and datapath stall.
//   clock, reset          clock and synchronous active-high reset
//   mem_read, mem_write   load/store requests (store wins when both are high)
//   addr, wd              byte address and store data from the datapath
//   rd                    last loaded word
//   stall                 freeze request while an aligned access is in flight
//   ack, misaligned       one-cycle completion and alignment-error strobes
module dmem_controller
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [WORD_W-1:0] wd,
    output logic [WORD_W-1:0] rd,
    output logic              stall,
    output logic              ack,
    output logic              misaligned
);

    localparam int IW = idx_w(DEPTH_WORDS);
    localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    dmem_state_t       state_d, state_q;
    logic [CW-1:0]     cnt_d, cnt_q;
    logic              store_d, store_q;
    logic [IW-1:0]     idx_d, idx_q;
    logic [WORD_W-1:0] wd_d, wd_q;
    logic              commit, cur_store;
    logic [IW-1:0]     ram_addr;
    logic [WORD_W-1:0] ram_wdata;
    logic              unused_addr;

    wire req     = mem_read | mem_write;
    wire aligned = addr[1:0] == 2'b00;

    assign unused_addr = &{1'b0, addr[31:IW+2]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        store_d    = store_q;
        idx_d      = idx_q;
        wd_d       = wd_q;
        commit     = 1'b0;
        stall      = 1'b0;
        ack        = 1'b0;
        misaligned = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !aligned) begin
                    misaligned = 1'b1;
                    ack        = 1'b1;
                end else if (req) begin
                    stall   = 1'b1;
                    store_d = mem_write;
                    idx_d   = addr[IW+1:2];
                    wd_d    = wd;
                    cnt_d   = '0;
                    commit  = WAIT_CYCLES == 0;
                    state_d = WAIT_CYCLES > 0 ? WAIT : DONE;
                end
            end
            WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    commit  = 1'b1;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                ack     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the commit edge is the IDLE edge, so the live inputs feed the RAM
    assign cur_store = state_q == IDLE ? mem_write : store_q;
    assign ram_addr  = state_q == IDLE ? addr[IW+1:2] : idx_q;
    assign ram_wdata = state_q == IDLE ? wd : wd_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            store_q <= 1'b0;
            idx_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            store_q <= store_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
        end
    end

    // Reset on the commit edge cancels the access, so enables are gated by reset
    dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clock (clock),
        .reset (reset),
        .we    (commit & cur_store & ~reset),
        .re    (commit & ~cur_store & ~reset),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (rd)
    );

endmodule

// File: tb/tb_dmem_controller.sv
// tb_dmem_controller: directed self-checking bench for dmem_controller (2 and 0 wait states).
module tb_dmem_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mr = '0, mw = '0;
    logic [31:0] ad [2];
    logic [31:0] wdv [2];
    logic [31:0] rdv [2];
    logic [1:0]  stl, ak, mis;
    int          errs = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    dmem_controller #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut_w2 (
        .clock(clock), .reset(reset), .mem_read(mr[0]), .mem_write(mw[0]),
        .addr(ad[0]), .wd(wdv[0]), .rd(rdv[0]), .stall(stl[0]), .ack(ak[0]), .misaligned(mis[0])
    );

    dmem_controller #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut_w0 (
        .clock(clock), .reset(reset), .mem_read(mr[1]), .mem_write(mw[1]),
        .addr(ad[1]), .wd(wdv[1]), .rd(rdv[1]), .stall(stl[1]), .ack(ak[1]), .misaligned(mis[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Full aligned access on instance k; request held until the DONE cycle
    task automatic access(input int k, input bit st, input bit both, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd, input bit chk_rd);
        int w;
        w = k == 0 ? 2 : 0;
        mr[k] = !st || both;
        mw[k] = st;
        ad[k] = a;
        wdv[k] = d;
        for (int c = 0; c <= w; c++) begin
            #1;
            check($sformatf("stall_c%0d_k%0d", c, k), stl[k], 1);
            check($sformatf("ack_c%0d_k%0d", c, k), ak[k], 0);
            step();
        end
        #1;
        check($sformatf("done_ack_k%0d", k), ak[k], 1);
        check($sformatf("done_stall_k%0d", k), stl[k], 0);
        check($sformatf("done_mis_k%0d", k), mis[k], 0);
        if (chk_rd) check($sformatf("rd_k%0d_%h", k, a), rdv[k], exp_rd);
        mr[k] = 1'b0;
        mw[k] = 1'b0;
        step();
    endtask

    initial begin
        ad[0] = '0; ad[1] = '0; wdv[0] = '0; wdv[1] = '0;
        step();
        step();
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_rd", rdv[k], 0);
            check("rst_stall", stl[k], 0);
            check("rst_ack", ak[k], 0);
            check("rst_mis", mis[k], 0);
        end
        step();

        access(0, 1, 0, 32'h10, 32'hDEADBEEF, 0, 0);
        access(0, 0, 0, 32'h10, 0, 32'hDEADBEEF, 1);

        // Misaligned load: strobes in the same cycle, no stall, rd unchanged
        mr[0] = 1'b1;
        ad[0] = 32'h12;
        #1;
        check("mis_strobe", mis[0], 1);
        check("mis_ack", ak[0], 1);
        check("mis_stall", stl[0], 0);
        step();
        mr[0] = 1'b0;
        #1;
        check("mis_clear", mis[0], 0);
        check("mis_ack_clear", ak[0], 0);
        check("mis_rd_kept", rdv[0], 32'hDEADBEEF);
        step();

        // Wrap-around: 0x100 maps to word 0 with 64 words
        access(0, 1, 0, 32'h0, 32'h1, 0, 0);
        access(0, 0, 0, 32'h100, 0, 32'h1, 1);

        // Both requests high: store wins
        access(0, 1, 1, 32'h30, 32'h55, 0, 0);
        access(0, 0, 0, 32'h30, 0, 32'h55, 1);

        // Reset in the second WAIT cycle cancels the store
        access(0, 1, 0, 32'h20, 32'h1234, 0, 0);
        access(0, 0, 0, 32'h20, 0, 32'h1234, 1);
        mw[0] = 1'b1;
        ad[0] = 32'h20;
        wdv[0] = 32'hAAAA;
        step();
        step();
        check("rstw_stall_before", stl[0], 1);
        reset = 1'b1;
        mw[0] = 1'b0;
        step();
        check("rstw_stall", stl[0], 0);
        check("rstw_ack", ak[0], 0);
        check("rstw_rd", rdv[0], 0);
        reset = 1'b0;
        step();
        access(0, 0, 0, 32'h20, 0, 32'h1234, 1);

        // Zero wait states
        access(1, 1, 0, 32'h8, 32'hCAFEF00D, 0, 0);
        access(1, 0, 0, 32'h8, 0, 32'hCAFEF00D, 1);
        access(1, 1, 0, 32'h4C, 32'h0BADF00D, 0, 0);
        access(1, 0, 0, 32'h14C, 0, 32'h0BADF00D, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
